// File: rtl/id_stage_if.sv
// Interface bundling the ID stage datapath and hazard signals.
// slave: seen from the decode stage. master: seen from the surrounding pipeline or a bench.
interface id_stage_if #(
  parameter int XLEN = 32
);
  // From IF/ID and fetch
  logic [XLEN-1:0] i_next_pc;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_fetch_pc4;
  // Writeback port
  logic            i_wb_we;
  logic [4:0]      i_wb_addr;
  logic [XLEN-1:0] i_wb_data;
  // EX/MEM hazard and forwarding info
  logic            i_exmem_regwr;
  logic            i_exmem_memrd;
  logic [4:0]      i_exmem_rd;
  logic [XLEN-1:0] i_exmem_data;
  // Back to fetch
  logic [XLEN-1:0] o_branch_addr;
  logic            o_pc_write;
  logic            o_ifid_write;
  logic            o_if_flush;
  // ID/EX register contents
  logic [XLEN-1:0] o_ex_next_pc;
  logic [XLEN-1:0] o_ex_rs_data;
  logic [XLEN-1:0] o_ex_rt_data;
  logic [XLEN-1:0] o_ex_imm;
  logic [4:0]      o_ex_rs;
  logic [4:0]      o_ex_rt;
  logic [4:0]      o_ex_rd;
  logic [7:0]      o_ex_ctrl;

  modport slave (
    input  i_next_pc, i_instr, i_fetch_pc4,
    input  i_wb_we, i_wb_addr, i_wb_data,
    input  i_exmem_regwr, i_exmem_memrd, i_exmem_rd, i_exmem_data,
    output o_branch_addr, o_pc_write, o_ifid_write, o_if_flush,
    output o_ex_next_pc, o_ex_rs_data, o_ex_rt_data, o_ex_imm,
    output o_ex_rs, o_ex_rt, o_ex_rd, o_ex_ctrl
  );

  modport master (
    output i_next_pc, i_instr, i_fetch_pc4,
    output i_wb_we, i_wb_addr, i_wb_data,
    output i_exmem_regwr, i_exmem_memrd, i_exmem_rd, i_exmem_data,
    input  o_branch_addr, o_pc_write, o_ifid_write, o_if_flush,
    input  o_ex_next_pc, o_ex_rs_data, o_ex_rt_data, o_ex_imm,
    input  o_ex_rs, o_ex_rt, o_ex_rd, o_ex_ctrl
  );
endinterface

// File: rtl/id_stage.sv
// Instruction Decode stage: register file, main decoder, load-use and branch
// hazard detection, early branch/jump resolution and the ID/EX register.
// Optional feature macro: ID_BRANCH_FWD_EN -- when defined, a branch operand
// produced by a non-load instruction in EX/MEM is taken from i_exmem_data
// instead of stalling one cycle for the WB write-through.
// Register numbers are 5 bits wide, so NREG must not exceed 32; the jump
// target concatenation assumes XLEN = 32.
module id_stage #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  id_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // Register file; entry 0 is never written and always reads as zero
  logic [XLEN-1:0] r_regs [NREG];

  // ID/EX register
  logic [XLEN-1:0] r_ex_next_pc;
  logic [XLEN-1:0] r_ex_rs_data;
  logic [XLEN-1:0] r_ex_rt_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [4:0]      r_ex_rs;
  logic [4:0]      r_ex_rt;
  logic [4:0]      r_ex_rd;
  logic [7:0]      r_ex_ctrl;

  // Instruction fields
  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_sext;

  // Decoder results
  logic [7:0]      w_ctrl;
  logic            w_uses_rt;
  logic            w_is_beq;
  logic            w_is_bne;
  logic            w_is_j;
  logic            w_is_branch;

  // Register reads (with write-through) and branch comparison operands
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic [XLEN-1:0] w_rs_cmp;
  logic [XLEN-1:0] w_rt_cmp;

  // Hazard terms
  logic [4:0]      w_ex_dest;
  logic            w_idex_hit_rs;
  logic            w_idex_hit_rt;
  logic            w_mem_load_hit_rs;
  logic            w_mem_load_hit_rt;
  logic            w_mem_alu_hit_rs;
  logic            w_mem_alu_hit_rt;
  logic            w_load_use;
  logic            w_br_stall;
  logic            w_stall;

  // Resolution
  logic [XLEN-1:0] w_branch_addr;
  logic            w_flush;

  assign w_op       = bus.i_instr[31:26];
  assign w_rs       = bus.i_instr[25:21];
  assign w_rt       = bus.i_instr[20:16];
  assign w_rd       = bus.i_instr[15:11];
  assign w_imm_sext = {{(XLEN-16){bus.i_instr[15]}}, bus.i_instr[15:0]};

  // Main decoder: control word and operand usage per opcode
  always_comb begin
    w_ctrl    = 8'b0000_0000;
    w_uses_rt = 1'b0;
    w_is_beq  = 1'b0;
    w_is_bne  = 1'b0;
    w_is_j    = 1'b0;
    case (w_op)
      OP_RTYPE: begin w_ctrl = 8'b1000_0111; w_uses_rt = 1'b1; end
      OP_LW:    begin w_ctrl = 8'b1101_1000; end
      OP_SW:    begin w_ctrl = 8'b0010_1000; w_uses_rt = 1'b1; end
      OP_ADDI:  begin w_ctrl = 8'b1000_1000; end
      OP_BEQ:   begin w_ctrl = 8'b0000_0001; w_uses_rt = 1'b1; w_is_beq = 1'b1; end
      OP_BNE:   begin w_ctrl = 8'b0000_0001; w_uses_rt = 1'b1; w_is_bne = 1'b1; end
      OP_J:     begin w_ctrl = 8'b0000_0001; w_is_j = 1'b1; end
      default:  begin w_ctrl = 8'b0000_0000; end
    endcase
  end

  assign w_is_branch = w_is_beq | w_is_bne;

  // Register file write port; r0 is skipped so it stays at its reset value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (bus.i_wb_we && (bus.i_wb_addr != 5'd0)) begin
      r_regs[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end

  // Read ports: a same-cycle WB to the read register bypasses the array
  always_comb begin
    w_rs_val = '0;
    w_rt_val = '0;
    if (w_rs != 5'd0)
      w_rs_val = (bus.i_wb_we && (bus.i_wb_addr == w_rs)) ? bus.i_wb_data : r_regs[w_rs];
    if (w_rt != 5'd0)
      w_rt_val = (bus.i_wb_we && (bus.i_wb_addr == w_rt)) ? bus.i_wb_data : r_regs[w_rt];
  end

  // Destination of the ID/EX instruction as EX will resolve it (regdst mux)
  assign w_ex_dest = r_ex_ctrl[2] ? r_ex_rd : r_ex_rt;

  assign w_idex_hit_rs     = r_ex_ctrl[7] && (w_ex_dest != 5'd0) && (w_ex_dest == w_rs);
  assign w_idex_hit_rt     = r_ex_ctrl[7] && (w_ex_dest != 5'd0) && (w_ex_dest == w_rt);
  assign w_mem_load_hit_rs = bus.i_exmem_regwr && bus.i_exmem_memrd &&
                             (bus.i_exmem_rd != 5'd0) && (bus.i_exmem_rd == w_rs);
  assign w_mem_load_hit_rt = bus.i_exmem_regwr && bus.i_exmem_memrd &&
                             (bus.i_exmem_rd != 5'd0) && (bus.i_exmem_rd == w_rt);
  assign w_mem_alu_hit_rs  = bus.i_exmem_regwr && !bus.i_exmem_memrd &&
                             (bus.i_exmem_rd != 5'd0) && (bus.i_exmem_rd == w_rs);
  assign w_mem_alu_hit_rt  = bus.i_exmem_regwr && !bus.i_exmem_memrd &&
                             (bus.i_exmem_rd != 5'd0) && (bus.i_exmem_rd == w_rt);

  // Load-use: the load in ID/EX produces rs (any instr) or rt (if rt is a source)
  assign w_load_use = r_ex_ctrl[6] && (r_ex_rt != 5'd0) &&
                      ((r_ex_rt == w_rs) || (w_uses_rt && (r_ex_rt == w_rt)));

  // Branch operand hazards: stall when a source is not yet available in ID
  always_comb begin
    w_br_stall = 1'b0;
    w_rs_cmp   = w_rs_val;
    w_rt_cmp   = w_rt_val;
    if (w_is_branch) begin
      if (w_idex_hit_rs || w_idex_hit_rt || w_mem_load_hit_rs || w_mem_load_hit_rt)
        w_br_stall = 1'b1;
`ifdef ID_BRANCH_FWD_EN
      if (w_mem_alu_hit_rs) w_rs_cmp = bus.i_exmem_data;
      if (w_mem_alu_hit_rt) w_rt_cmp = bus.i_exmem_data;
`else
      if (w_mem_alu_hit_rs || w_mem_alu_hit_rt)
        w_br_stall = 1'b1;
`endif
    end
  end

  assign w_stall = w_load_use | w_br_stall;

  // Early resolution of taken branches and jumps; a stall suppresses redirection
  always_comb begin
    w_branch_addr = bus.i_fetch_pc4;
    w_flush       = 1'b0;
    if (!w_stall) begin
      if ((w_is_beq && (w_rs_cmp == w_rt_cmp)) || (w_is_bne && (w_rs_cmp != w_rt_cmp))) begin
        w_branch_addr = bus.i_next_pc + {w_imm_sext[XLEN-3:0], 2'b00};
        w_flush       = 1'b1;
      end else if (w_is_j) begin
        w_branch_addr = {bus.i_next_pc[XLEN-1:XLEN-4], bus.i_instr[25:0], 2'b00};
        w_flush       = 1'b1;
      end
    end
  end

  // Fetch-side controls are forced to their idle values while reset is held
  assign bus.o_pc_write    = i_rst | ~w_stall;
  assign bus.o_ifid_write  = i_rst | ~w_stall;
  assign bus.o_if_flush    = ~i_rst & w_flush;
  assign bus.o_branch_addr = i_rst ? bus.i_fetch_pc4 : w_branch_addr;

  // ID/EX register: loads every edge; stalls and unknown opcodes become bubbles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex_next_pc <= '0;
      r_ex_rs_data <= '0;
      r_ex_rt_data <= '0;
      r_ex_imm     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_ex_ctrl    <= '0;
    end else begin
      r_ex_next_pc <= bus.i_next_pc;
      r_ex_rs_data <= w_rs_val;
      r_ex_rt_data <= w_rt_val;
      r_ex_imm     <= w_imm_sext;
      r_ex_rs      <= w_rs;
      r_ex_rt      <= w_rt;
      r_ex_rd      <= w_rd;
      r_ex_ctrl    <= w_stall ? 8'b0000_0000 : w_ctrl;
    end
  end

  assign bus.o_ex_next_pc = r_ex_next_pc;
  assign bus.o_ex_rs_data = r_ex_rs_data;
  assign bus.o_ex_rt_data = r_ex_rt_data;
  assign bus.o_ex_imm     = r_ex_imm;
  assign bus.o_ex_rs      = r_ex_rs;
  assign bus.o_ex_rt      = r_ex_rt;
  assign bus.o_ex_rd      = r_ex_rd;
  assign bus.o_ex_ctrl    = r_ex_ctrl;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by a random
// run checked against an instruction-level model of decode and hazards.
module tb_id_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  id_stage_if bus ();

  id_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: architectural registers and the instruction sitting in ID/EX
  logic [31:0] mreg [32];
  logic [7:0]  m_ex_ctrl;
  logic [4:0]  m_ex_rt;
  logic [4:0]  m_ex_rd;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [7:0] m_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 8'h87;
      6'h23:   return 8'hD8;
      6'h2B:   return 8'h28;
      6'h08:   return 8'h88;
      6'h04:   return 8'h01;
      6'h05:   return 8'h01;
      6'h02:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Architectural read value seen in ID, including this cycle's writeback
  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (bus.i_wb_we && bus.i_wb_addr == r) return bus.i_wb_data;
    return mreg[r];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_next_pc     = 32'h0;
    bus.i_instr       = 32'h0;
    bus.i_fetch_pc4   = 32'h0;
    bus.i_wb_we       = 1'b0;
    bus.i_wb_addr     = 5'd0;
    bus.i_wb_data     = 32'h0;
    bus.i_exmem_regwr = 1'b0;
    bus.i_exmem_memrd = 1'b0;
    bus.i_exmem_rd    = 5'd0;
    bus.i_exmem_data  = 32'h0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    bus.i_instr   = 32'h0;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = a;
    bus.i_wb_data = d;
    tick();
    bus.i_wb_we   = 1'b0;
  endtask

  task automatic test_reset();
    // power-on reset already asserted
    bus.i_fetch_pc4 = 32'h0000_0ABC;
    #1;
    n_checks++; if (bus.o_ex_ctrl !== 8'h00) begin n_fail++; $display("FAIL por_ctrl: got %h want 00", bus.o_ex_ctrl); end
    n_checks++; if (bus.o_pc_write !== 1'b1) begin n_fail++; $display("FAIL por_pc_write: got %b want 1", bus.o_pc_write); end
    n_checks++; if (bus.o_ifid_write !== 1'b1) begin n_fail++; $display("FAIL por_ifid_write: got %b want 1", bus.o_ifid_write); end
    n_checks++; if (bus.o_if_flush !== 1'b0) begin n_fail++; $display("FAIL por_flush: got %b want 0", bus.o_if_flush); end
    n_checks++; if (bus.o_branch_addr !== 32'h0000_0ABC) begin n_fail++; $display("FAIL por_addr: got %h want 00000abc", bus.o_branch_addr); end
    tick();
    rst = 1'b0;
    // mid-run reset while ID/EX holds lw r5
    wb_write(5'd5, 32'h0000_0055);
    bus.i_instr = enc_i(6'h23, 5'd1, 5'd5, 16'h0);
    tick();
    n_checks++; if (bus.o_ex_ctrl !== 8'hD8) begin n_fail++; $display("FAIL rst_pre_lw_ctrl: got %h want d8", bus.o_ex_ctrl); end
    bus.i_instr   = 32'h0800_0040;
    bus.i_next_pc = 32'h3000_0010;
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.o_ex_ctrl !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl: got %h want 00", bus.o_ex_ctrl); end
    n_checks++; if (bus.o_pc_write !== 1'b1) begin n_fail++; $display("FAIL rst_pc_write: got %b want 1", bus.o_pc_write); end
    n_checks++; if (bus.o_if_flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", bus.o_if_flush); end
    n_checks++; if (bus.o_branch_addr !== 32'h0000_0ABC) begin n_fail++; $display("FAIL rst_addr: got %h want 00000abc", bus.o_branch_addr); end
    tick();
    rst = 1'b0;
    idle();
    bus.i_instr = enc_r(5'd5, 5'd0, 5'd6);
    tick();
    n_checks++; if (bus.o_ex_rs_data !== 32'h0) begin n_fail++; $display("FAIL rst_r5: got %h want 0", bus.o_ex_rs_data); end
    n_checks++; if (bus.o_ex_ctrl !== 8'h87) begin n_fail++; $display("FAIL rst_add_ctrl: got %h want 87", bus.o_ex_ctrl); end
    $display("test_reset done");
  endtask

  task automatic test_write_through();
    idle();
    bus.i_instr   = enc_r(5'd3, 5'd0, 5'd4);
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = 5'd3;
    bus.i_wb_data = 32'h0000_1234;
    tick();
    n_checks++; if (bus.o_ex_rs_data !== 32'h0000_1234) begin n_fail++; $display("FAIL wt_rs_data: got %h want 00001234", bus.o_ex_rs_data); end
    n_checks++; if (bus.o_ex_rd !== 5'd4) begin n_fail++; $display("FAIL wt_rd: got %0d want 4", bus.o_ex_rd); end
    bus.i_wb_addr = 5'd0;
    bus.i_wb_data = 32'hFFFF_FFFF;
    bus.i_instr   = enc_r(5'd0, 5'd3, 5'd4);
    tick();
    n_checks++; if (bus.o_ex_rs_data !== 32'h0) begin n_fail++; $display("FAIL wt_r0_same: got %h want 0", bus.o_ex_rs_data); end
    n_checks++; if (bus.o_ex_rt_data !== 32'h0000_1234) begin n_fail++; $display("FAIL wt_r3_stored: got %h want 00001234", bus.o_ex_rt_data); end
    bus.i_wb_we = 1'b0;
    tick();
    n_checks++; if (bus.o_ex_rs_data !== 32'h0) begin n_fail++; $display("FAIL wt_r0_after: got %h want 0", bus.o_ex_rs_data); end
    $display("test_write_through done");
  endtask

  task automatic test_load_use();
    idle();
    bus.i_instr = enc_i(6'h23, 5'd1, 5'd2, 16'h0);
    tick();
    n_checks++; if (bus.o_ex_ctrl !== 8'hD8) begin n_fail++; $display("FAIL lu_lw_ctrl: got %h want d8", bus.o_ex_ctrl); end
    bus.i_instr = enc_r(5'd2, 5'd2, 5'd3);
    #1;
    n_checks++; if (bus.o_pc_write !== 1'b0) begin n_fail++; $display("FAIL lu_pc_write: got %b want 0", bus.o_pc_write); end
    n_checks++; if (bus.o_ifid_write !== 1'b0) begin n_fail++; $display("FAIL lu_ifid_write: got %b want 0", bus.o_ifid_write); end
    tick();
    n_checks++; if (bus.o_ex_ctrl !== 8'h00) begin n_fail++; $display("FAIL lu_bubble: got %h want 00", bus.o_ex_ctrl); end
    n_checks++; if (bus.o_pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_release: got %b want 1", bus.o_pc_write); end
    tick();
    n_checks++; if (bus.o_ex_ctrl !== 8'h87 || bus.o_ex_rd !== 5'd3) begin n_fail++; $display("FAIL lu_issue: got ctrl %h rd %0d want 87 3", bus.o_ex_ctrl, bus.o_ex_rd); end
    $display("test_load_use done");
  endtask

  task automatic test_beq();
    idle();
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    bus.i_instr     = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
    bus.i_next_pc   = 32'h0000_0100;
    bus.i_fetch_pc4 = 32'h0000_0200;
    #1;
    n_checks++; if (bus.o_branch_addr !== 32'h0000_00F8) begin n_fail++; $display("FAIL beq_addr: got %h want 000000f8", bus.o_branch_addr); end
    n_checks++; if (bus.o_if_flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush: got %b want 1", bus.o_if_flush); end
    tick();
    bus.i_instr = 32'h0;
    #1;
    n_checks++; if (bus.o_if_flush !== 1'b0) begin n_fail++; $display("FAIL beq_bubble_flush: got %b want 0", bus.o_if_flush); end
    wb_write(5'd2, 32'd8);
    bus.i_instr = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
    #1;
    n_checks++; if (bus.o_branch_addr !== 32'h0000_0200 || bus.o_if_flush !== 1'b0) begin n_fail++; $display("FAIL beq_nt: got %h/%b want 00000200/0", bus.o_branch_addr, bus.o_if_flush); end
    tick();
    $display("test_beq done");
  endtask

  task automatic test_jump();
    idle();
    bus.i_instr   = 32'h0800_0040;
    bus.i_next_pc = 32'h3000_0010;
    #1;
    n_checks++; if (bus.o_branch_addr !== 32'h3000_0100) begin n_fail++; $display("FAIL j_addr: got %h want 30000100", bus.o_branch_addr); end
    n_checks++; if (bus.o_if_flush !== 1'b1) begin n_fail++; $display("FAIL j_flush: got %b want 1", bus.o_if_flush); end
    tick();
    $display("test_jump done");
  endtask

  task automatic test_branch_fwd();
    int stalls;
    idle();
    wb_write(5'd6, 32'd0);
    wb_write(5'd7, 32'd9);
    bus.i_instr       = enc_i(6'h04, 5'd6, 5'd7, 16'h0004);
    bus.i_next_pc     = 32'h0000_1000;
    bus.i_exmem_regwr = 1'b1;
    bus.i_exmem_rd    = 5'd6;
    bus.i_exmem_data  = 32'd9;
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.o_pc_write === 1'b1) break;
      stalls++;
      tick();
      // the ALU result moves from EX/MEM into WB
      bus.i_exmem_regwr = 1'b0;
      bus.i_wb_we       = 1'b1;
      bus.i_wb_addr     = 5'd6;
      bus.i_wb_data     = 32'd9;
    end
`ifdef ID_BRANCH_FWD_EN
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL fwd_alu_stalls: got %0d want 0", stalls); end
`else
    n_checks++; if (stalls != 1) begin n_fail++; $display("FAIL fwd_alu_stalls: got %0d want 1", stalls); end
`endif
    n_checks++; if (bus.o_if_flush !== 1'b1 || bus.o_branch_addr !== 32'h0000_1010) begin n_fail++; $display("FAIL fwd_alu_taken: got %b/%h want 1/00001010", bus.o_if_flush, bus.o_branch_addr); end
    tick();
    idle();
    // branch right behind a load of r8
    bus.i_instr = enc_i(6'h23, 5'd0, 5'd8, 16'h0);
    tick();
    bus.i_instr   = enc_i(6'h04, 5'd8, 5'd7, 16'h0004);
    bus.i_next_pc = 32'h0000_1000;
    stalls = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.o_pc_write === 1'b1) break;
      stalls++;
      tick();
      if (stalls == 1) begin
        bus.i_exmem_regwr = 1'b1;
        bus.i_exmem_memrd = 1'b1;
        bus.i_exmem_rd    = 5'd8;
        bus.i_exmem_data  = 32'h0;
      end else begin
        bus.i_exmem_regwr = 1'b0;
        bus.i_exmem_memrd = 1'b0;
        bus.i_wb_we       = 1'b1;
        bus.i_wb_addr     = 5'd8;
        bus.i_wb_data     = 32'd9;
      end
    end
    n_checks++; if (stalls != 2) begin n_fail++; $display("FAIL fwd_load_stalls: got %0d want 2", stalls); end
    n_checks++; if (bus.o_if_flush !== 1'b1) begin n_fail++; $display("FAIL fwd_load_taken: got %b want 1", bus.o_if_flush); end
    tick();
    idle();
    $display("test_branch_fwd done stalls_after_load=%0d", stalls);
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] ins;
    logic [4:0]  src [2];
    logic [31:0] val [2];
    logic [4:0]  ex_dest;
    logic        stall;
    logic        uses_rt;
    logic [31:0] exp_addr;
    logic        exp_flush;
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_rs_data, exp_rt_data, exp_imm, exp_npc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    int          n_stall, n_flush;

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    m_ex_ctrl = 8'h00; m_ex_rt = 5'd0; m_ex_rd = 5'd0;
    n_stall = 0; n_flush = 0;

    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h05;
        5: op = 6'h08;
        6: op = 6'h02;
        default: op = 6'h3F;
      endcase
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
      bus.i_instr       = ins;
      bus.i_next_pc     = $urandom;
      bus.i_fetch_pc4   = $urandom;
      bus.i_wb_we       = 1'($urandom_range(0, 1));
      bus.i_wb_addr     = 5'($urandom_range(0, 7));
      bus.i_wb_data     = $urandom_range(0, 3);
      bus.i_exmem_regwr = 1'($urandom_range(0, 1));
      bus.i_exmem_memrd = bus.i_exmem_regwr & 1'($urandom_range(0, 1));
      bus.i_exmem_rd    = 5'($urandom_range(0, 7));
      bus.i_exmem_data  = $urandom_range(0, 3);

      // expected behaviour of this instruction in ID
      src[0]  = ins[25:21];
      src[1]  = ins[20:16];
      val[0]  = m_read(src[0]);
      val[1]  = m_read(src[1]);
      uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
      stall   = m_ex_ctrl[6] && (m_ex_rt != 0) && (m_ex_rt == src[0] || (uses_rt && m_ex_rt == src[1]));
      ex_dest = m_ex_ctrl[2] ? m_ex_rd : m_ex_rt;
      if (op == 6'h04 || op == 6'h05) begin
        for (int k = 0; k < 2; k++) begin
          if (m_ex_ctrl[7] && ex_dest != 0 && ex_dest == src[k]) stall = 1'b1;
          if (bus.i_exmem_regwr && bus.i_exmem_rd != 0 && bus.i_exmem_rd == src[k]) begin
            if (bus.i_exmem_memrd) stall = 1'b1;
`ifdef ID_BRANCH_FWD_EN
            else val[k] = bus.i_exmem_data;
`else
            else stall = 1'b1;
`endif
          end
        end
      end
      exp_addr  = bus.i_fetch_pc4;
      exp_flush = 1'b0;
      if (!stall) begin
        if ((op == 6'h04 && val[0] == val[1]) || (op == 6'h05 && val[0] != val[1])) begin
          exp_addr  = bus.i_next_pc + 32'($signed(ins[15:0])) * 4;
          exp_flush = 1'b1;
        end else if (op == 6'h02) begin
          exp_addr  = {bus.i_next_pc[31:28], ins[25:0], 2'b00};
          exp_flush = 1'b1;
        end
      end
      exp_ctrl    = stall ? 8'h00 : m_ctrl(op);
      exp_rs_data = m_read(src[0]);
      exp_rt_data = m_read(src[1]);
      exp_imm     = 32'($signed(ins[15:0]));
      exp_npc     = bus.i_next_pc;
      wb_we = bus.i_wb_we; wb_addr = bus.i_wb_addr; wb_data = bus.i_wb_data;
      if (stall) n_stall++;
      if (exp_flush) n_flush++;

      #1;
      n_checks++; if (bus.o_pc_write !== ~stall || bus.o_ifid_write !== ~stall) begin n_fail++; $display("FAIL rnd_stall c=%0d instr=%h: got pc_wr %b ifid_wr %b want %b", c, ins, bus.o_pc_write, bus.o_ifid_write, ~stall); end
      n_checks++; if (bus.o_if_flush !== exp_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d instr=%h: got %b want %b", c, ins, bus.o_if_flush, exp_flush); end
      n_checks++; if (bus.o_branch_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d instr=%h: got %h want %h", c, ins, bus.o_branch_addr, exp_addr); end
      tick();
      n_checks++; if (bus.o_ex_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rnd_ctrl c=%0d instr=%h: got %h want %h", c, ins, bus.o_ex_ctrl, exp_ctrl); end
      if (exp_ctrl != 8'h00) begin
        n_checks++; if (bus.o_ex_rs_data !== exp_rs_data || bus.o_ex_rt_data !== exp_rt_data) begin n_fail++; $display("FAIL rnd_data c=%0d: got %h %h want %h %h", c, bus.o_ex_rs_data, bus.o_ex_rt_data, exp_rs_data, exp_rt_data); end
        n_checks++; if (bus.o_ex_imm !== exp_imm || bus.o_ex_next_pc !== exp_npc) begin n_fail++; $display("FAIL rnd_imm_pc c=%0d: got %h %h want %h %h", c, bus.o_ex_imm, bus.o_ex_next_pc, exp_imm, exp_npc); end
        n_checks++; if (bus.o_ex_rs !== src[0] || bus.o_ex_rt !== src[1] || bus.o_ex_rd !== ins[15:11]) begin n_fail++; $display("FAIL rnd_regs c=%0d: got %0d %0d %0d want %0d %0d %0d", c, bus.o_ex_rs, bus.o_ex_rt, bus.o_ex_rd, src[0], src[1], ins[15:11]); end
      end
      if (wb_we && wb_addr != 0) mreg[wb_addr] = wb_data;
      m_ex_ctrl = exp_ctrl;
      m_ex_rt   = src[1];
      m_ex_rd   = ins[15:11];
    end
    idle();
    $display("test_random done stalls=%0d flushes=%0d", n_stall, n_flush);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_write_through();
    test_load_use();
    test_beq();
    test_jump();
    test_branch_fwd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
